// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: multi-channel hobby-servo PWM generator with handshaked
// angle writes, frame-synchronous slew-limited updates and a 4-digit
// seven-segment readout of one channel's live angle.
module servo_pwm_bank #(
    parameter int NUM_CH      = 5,
    parameter int CLK_HZ      = 50_000_000,
    parameter int PERIOD_US   = 20000,
    parameter int MIN_US      = 500,
    parameter int MAX_US      = 2500,
    parameter int RESET_ANGLE = 90,
    parameter int SLEW_STEP   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [3:0]        wr_ch,
    input  logic [7:0]        wr_angle,
    input  logic [3:0]        disp_sel,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_tick,
    output logic              busy,
    output logic [3:0][6:0]   seven_seg_display
);

    localparam int CYC_PER_US = CLK_HZ / 1_000_000;
    localparam int PRE_W      = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam int US_MAX     = (PERIOD_US > MAX_US) ? PERIOD_US : MAX_US;
    localparam int US_W       = $clog2(US_MAX + 1);
    // Rounded fixed-point degrees-to-microseconds factor (8 fractional bits).
    localparam int SCALE      = ((MAX_US - MIN_US) * 256 + 90) / 180;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYC_PER_US - 1);
    localparam logic [US_W-1:0]  US_LAST  = US_W'(PERIOD_US - 1);
    localparam logic [7:0]       RESET8   = 8'(RESET_ANGLE);
    localparam logic [7:0]       STEP8    = 8'(SLEW_STEP);

    // Pulse width in microseconds for a given angle.
    function automatic logic [US_W-1:0] angle_to_us(input logic [7:0] a);
        logic [31:0] prod;
        prod = 32'(a) * 32'(SCALE);
        return US_W'(32'(MIN_US) + (prod >> 8));
    endfunction

    // Active-low segment pattern (bit0=a .. bit6=g) for one hex digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] pat;
        case (d)
            4'h0: pat = 7'h3F;  4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;  4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;  4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;  4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;  4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;  4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;  4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;  default: pat = 7'h71;
        endcase
        return ~pat;
    endfunction

    logic [PRE_W-1:0]    pre_reg;
    logic [US_W-1:0]     us_reg;
    logic                pre_wrap;
    logic                frame_start;
    logic                wr_accept;
    logic [7:0]          wr_clamped;
    logic                frame_tick_reg;
    logic                busy_reg;
    logic [NUM_CH-1:0]   diff_vec;
    logic [7:0]          cur_w [NUM_CH];
    logic [7:0]          sel_angle;
    logic                sel_valid;
    logic [3:0][6:0]     disp_reg;
    logic [3:0][6:0]     disp_next;

    assign wr_ready    = ~reset;
    assign wr_accept   = wr_valid && wr_ready;
    assign wr_clamped  = (wr_angle > 8'd180) ? 8'd180 : wr_angle;
    assign pre_wrap    = (pre_reg == PRE_LAST);
    assign frame_start = (pre_reg == '0) && (us_reg == '0);

    // Microsecond prescaler and position-within-frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_reg <= '0;
            us_reg  <= '0;
        end else if (pre_wrap) begin
            pre_reg <= '0;
            us_reg  <= (us_reg == US_LAST) ? '0 : us_reg + 1'b1;
        end else begin
            pre_reg <= pre_reg + 1'b1;
        end
    end

    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [7:0]      tgt_reg;
        logic [7:0]      cur_reg;
        logic [7:0]      cur_next;
        logic [US_W-1:0] pulse_reg;
        logic [US_W-1:0] pulse_next;
        logic            pwm_reg;
        logic            wr_hit;

        assign wr_hit = wr_accept && (wr_ch == 4'(gi));

        // Slew-limited step of the live angle toward its target.
        always_comb begin
            cur_next = cur_reg;
            if (SLEW_STEP == 0) begin
                cur_next = tgt_reg;
            end else if (tgt_reg > cur_reg) begin
                cur_next = ((tgt_reg - cur_reg) > STEP8) ? cur_reg + STEP8 : tgt_reg;
            end else if (tgt_reg < cur_reg) begin
                cur_next = ((cur_reg - tgt_reg) > STEP8) ? cur_reg - STEP8 : tgt_reg;
            end
        end

        assign pulse_next = angle_to_us(cur_next);

        // Target capture, frame-start angle/pulse update and pulse output.
        // The frame-start cycle compares against the freshly computed width
        // so the first pulse of a frame already uses the new value.
        always_ff @(posedge clk) begin
            if (reset) begin
                tgt_reg   <= RESET8;
                cur_reg   <= RESET8;
                pulse_reg <= angle_to_us(RESET8);
                pwm_reg   <= 1'b0;
            end else begin
                if (wr_hit) begin
                    tgt_reg <= wr_clamped;
                end
                if (frame_start) begin
                    cur_reg   <= cur_next;
                    pulse_reg <= pulse_next;
                end
                pwm_reg <= (us_reg < (frame_start ? pulse_next : pulse_reg));
            end
        end

        assign cur_w[gi]    = cur_reg;
        assign diff_vec[gi] = (cur_reg != tgt_reg);
        assign pwm_out[gi]  = pwm_reg;
    end

    // Frame tick marks the first cycle of each frame's pulses; busy flags
    // any channel still slewing or awaiting a frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_tick_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            frame_tick_reg <= frame_start;
            busy_reg       <= |diff_vec;
        end
    end

    // Select the displayed channel's live angle.
    always_comb begin
        sel_angle = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (disp_sel == 4'(i)) begin
                sel_angle = cur_w[i];
            end
        end
    end

    assign sel_valid = ({28'd0, disp_sel} < 32'(NUM_CH));

    // Decimal split and segment decode; dashes for a nonexistent channel.
    always_comb begin
        disp_next = {4{7'b0111111}};
        if (sel_valid) begin
            disp_next[3] = seg7(disp_sel);
            disp_next[2] = seg7(4'(sel_angle / 8'd100));
            disp_next[1] = seg7(4'((sel_angle / 8'd10) % 8'd10));
            disp_next[0] = seg7(4'(sel_angle % 8'd10));
        end
    end

    // Registered display output; blank while in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_reg <= '1;
        end else begin
            disp_reg <= disp_next;
        end
    end

    assign frame_tick        = frame_tick_reg;
    assign busy              = busy_reg;
    assign seven_seg_display = disp_reg;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Testbench for servo_pwm_bank: two instances (no slew / slew 2) share the
// same stimulus; a frame monitor measures pulse widths of the no-slew
// instance and checks them against a queue of expected frames.
module tb_servo_pwm_bank;

    localparam int NCH    = 5;
    localparam int PERIOD = 3000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              wr_valid = 1'b0;
    logic [3:0]        wr_ch = '0;
    logic [7:0]        wr_angle = '0;
    logic [3:0]        disp_sel = '0;
    logic              wr_ready0, wr_ready1;
    logic [NCH-1:0]    pwm0, pwm1;
    logic              tick0, tick1;
    logic              busy0, busy1;
    logic [3:0][6:0]   seg0, seg1;

    always #5 clk = ~clk;

    servo_pwm_bank #(
        .NUM_CH(NCH), .CLK_HZ(1_000_000), .PERIOD_US(PERIOD), .MIN_US(500),
        .MAX_US(2500), .RESET_ANGLE(90), .SLEW_STEP(0)
    ) dut0 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready0),
        .wr_ch(wr_ch), .wr_angle(wr_angle), .disp_sel(disp_sel),
        .pwm_out(pwm0), .frame_tick(tick0), .busy(busy0),
        .seven_seg_display(seg0)
    );

    servo_pwm_bank #(
        .NUM_CH(NCH), .CLK_HZ(1_000_000), .PERIOD_US(PERIOD), .MIN_US(500),
        .MAX_US(2500), .RESET_ANGLE(90), .SLEW_STEP(2)
    ) dut1 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready1),
        .wr_ch(wr_ch), .wr_angle(wr_angle), .disp_sel(disp_sel),
        .pwm_out(pwm1), .frame_tick(tick1), .busy(busy1),
        .seven_seg_display(seg1)
    );

    typedef struct packed {
        logic [NCH-1:0][11:0] w;
    } frame_t;

    typedef struct {
        int ch;
        int angle;
        int exp_w;
        bit same;
    } vec_t;

    localparam logic [6:0] SEG_HI [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    frame_t exp_q [$];
    int     model_w [NCH];
    int     n_cmp = 0;
    int     n_bad = 0;
    vec_t   vec [7];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] hi;
        hi = SEG_HI[d];
        return ~hi;
    endfunction

    function automatic int disp_exp(input int ch, input int ang);
        logic [27:0] v;
        v = {seg_of(ch), seg_of(ang / 100), seg_of((ang / 10) % 10), seg_of(ang % 10)};
        return int'(v);
    endfunction

    task automatic push_exp();
        frame_t e;
        for (int c = 0; c < NCH; c++) e.w[c] = 12'(model_w[c]);
        exp_q.push_back(e);
    endtask

    task automatic wait_tick(input bit push);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick0 && n < 4000);
        n_cmp++;
        if (!tick0) begin
            n_bad++;
            $display("FAIL tick_timeout: got no frame_tick in %0d cycles, required one", n);
        end else if (push) begin
            push_exp();
        end
    endtask

    task automatic do_write(input int ch, input int ang);
        wr_valid = 1'b1;
        wr_ch    = 4'(ch);
        wr_angle = 8'(ang);
        @(negedge clk);
        wr_valid = 1'b0;
        $display("write ch=%0d angle=%0d", ch, ang);
    endtask

    // Frame monitor: one frame runs from one frame_tick to the next.
    initial begin
        int  cnt [NCH];
        int  cyc;
        bit  in_frame;
        int  fno;
        frame_t e;
        in_frame = 1'b0;
        fno = 0;
        cyc = 0;
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_frame = 1'b0;
            end else begin
                if (tick0) begin
                    if (in_frame) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL scoreboard: got frame %0d with no expected entry", fno);
                        end else begin
                            e = exp_q.pop_front();
                            for (int c = 0; c < NCH; c++)
                                check($sformatf("width_f%0d_ch%0d", fno, c), cnt[c], int'(e.w[c]));
                            check($sformatf("period_f%0d", fno), cyc, PERIOD);
                            $display("frame %0d: widths %0d %0d %0d %0d %0d period %0d",
                                     fno, cnt[0], cnt[1], cnt[2], cnt[3], cnt[4], cyc);
                        end
                        fno++;
                    end
                    in_frame = 1'b1;
                    cyc = 0;
                    for (int c = 0; c < NCH; c++) cnt[c] = 0;
                end
                if (in_frame) begin
                    cyc++;
                    for (int c = 0; c < NCH; c++) cnt[c] += int'(pwm0[c]);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #950_000;
        $display("FAIL watchdog: got simulation still running, required finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec[0] = '{2, 180, 2499, 1'b0};
        vec[1] = '{0, 0,   500,  1'b1};
        vec[2] = '{3, 250, 2499, 1'b0};
        vec[3] = '{7, 33,  0,    1'b0};
        vec[4] = '{4, 40,  944,  1'b0};
        vec[5] = '{4, 60,  1166, 1'b1};
        vec[6] = '{4, 7,   577,  1'b0};
        for (int c = 0; c < NCH; c++) model_w[c] = 1499;

        // Reset state.
        repeat (4) @(negedge clk);
        check("rst_pwm", int'(pwm0), 0);
        check("rst_tick", int'(tick0), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_ready", int'(wr_ready0), 0);
        reset = 1'b0;

        // First cycle after release is F; pulses and tick appear at F+1.
        @(negedge clk);
        check("first_tick", int'(tick0), 1);
        check("first_pwm", int'(pwm0), 5'b11111);
        check("disp_reset", int'(seg0), disp_exp(0, 90));
        check("ready_run", int'(wr_ready0), 1);
        push_exp();

        // Slew sequence on the slew-limited instance.
        repeat (100) @(negedge clk);
        do_write(1, 100);
        model_w[1] = 1610;
        @(negedge clk);
        check("busy_after_wr", int'(busy0), 1);
        disp_sel = 4'd1;
        for (int k = 1; k <= 5; k++) begin
            wait_tick(1'b1);
            check($sformatf("slew_busy_pre_%0d", k), int'(busy1), 1);
            @(negedge clk);
            check($sformatf("slew_disp_%0d", k), int'(seg1), disp_exp(1, 90 + 2 * k));
            check($sformatf("slew_busy_%0d", k), int'(busy1), (k < 5) ? 1 : 0);
            if (k == 1) begin
                check("noslew_busy", int'(busy0), 0);
                check("noslew_disp", int'(seg0), disp_exp(1, 100));
            end
            $display("slew frame %0d: busy=%0b", k, busy1);
        end

        // Table of writes: clamp, out-of-range channel, last-write-wins.
        for (int i = 0; i < 7; i++) begin
            if (!vec[i].same) begin
                wait_tick(1'b1);
                repeat (200) @(negedge clk);
            end
            do_write(vec[i].ch, vec[i].angle);
            if (vec[i].ch < NCH) model_w[vec[i].ch] = vec[i].exp_w;
            check($sformatf("wr_ready_%0d", i), int'(wr_ready0), 1);
        end
        wait_tick(1'b1);

        // Display of channel 4 at 7 degrees, then an invalid channel.
        disp_sel = 4'd4;
        @(negedge clk);
        @(negedge clk);
        check("disp_4007", int'(seg0), disp_exp(4, 7));
        disp_sel = 4'd9;
        @(negedge clk);
        @(negedge clk);
        check("disp_dash", int'(seg0), int'({4{7'b0111111}}));
        disp_sel = 4'd0;

        // Write accepted exactly in frame-start cycle F.
        wait_tick(1'b1);
        repeat (PERIOD - 1) @(negedge clk);
        do_write(0, 180);
        check("f_align", int'(tick0), 1);
        push_exp();
        model_w[0] = 2499;
        wait_tick(1'b1);

        // Reset in the middle of a pulse, with a write presented during reset.
        wait_tick(1'b1);
        repeat (100) @(negedge clk);
        check("pwm_before_rst", int'(pwm0), 5'b11111);
        reset = 1'b1;
        exp_q.delete();
        wr_valid = 1'b1;
        wr_ch    = 4'd0;
        wr_angle = 8'd10;
        @(negedge clk);
        check("rst_mid_pwm", int'(pwm0), 0);
        check("rst_mid_ready", int'(wr_ready0), 0);
        repeat (3) @(negedge clk);
        wr_valid = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < NCH; c++) model_w[c] = 1499;
        wait_tick(1'b1);
        wait_tick(1'b0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/servo_pwm_bank.md
# servo_pwm_bank

Parametrised multi-channel hobby-servo driver for the bionic arm: it generates one PWM pulse train per finger/wrist servo from per-channel angle commands. It replaces the fixed five-channel PWM test generator, and adds five things: a write handshake for angle targets, frame-synchronous updates, per-channel slew limiting, angle clamping, and a seven-segment readout of any selected channel's live angle. It sits between the command logic (sensor/FSM front end) and the servo output pins.

## Interface
- NUM_CH, 5: number of servo channels (1..16)
- CLK_HZ, 50_000_000: clock frequency; CYC_PER_US = CLK_HZ/1_000_000, which must be an integer
- PERIOD_US, 20000: PWM frame length in µs
- MIN_US, 500: pulse width at 0°
- MAX_US, 2500: pulse width at 180°
- RESET_ANGLE, 90: angle loaded into all channels on reset
- SLEW_STEP, 2: maximum change of the live angle per frame, in degrees; 0 means no limit
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  angle write request
- wr_ready  out  1  block can accept a write
- wr_ch  in  4  target channel index
- wr_angle  in  8  target angle in degrees
- disp_sel  in  4  channel shown on the display
- pwm_out  out  NUM_CH  servo pulse outputs
- frame_tick  out  1  one-cycle pulse at the start of each frame's pulses
- busy  out  1  high while any channel's live angle differs from its target
- seven_seg_display  out  [3:0][6:0]  digits: [3]=channel, [2]=hundreds, [1]=tens, [0]=ones of the live angle

## Operation
- Each channel holds two values: a target angle tgt[i] and a live angle cur[i], both 8 bits.
- **Write handshake:** a write is accepted when wr_valid && wr_ready on a clock edge. Accepting a write sets tgt[wr_ch] = min(wr_angle, 180).
  - Writes with wr_ch >= NUM_CH are accepted and then discarded.
  - If the same channel is written more than once within a frame, the last write wins.
- wr_ready is 0 during reset and 1 otherwise.
- **Counters:** a prescaler counts 0..CYC_PER_US-1. The µs counter frame_us counts 0..PERIOD_US-1 and advances when the prescaler wraps. Both counters wrap to 0.
- **Frame-start cycle F:** the cycle where prescaler==0 and frame_us==0. In cycle F, for every channel:
  - cur moves toward tgt by min(|tgt-cur|, SLEW_STEP); with SLEW_STEP=0, cur takes tgt directly.
  - pulse_us[i] is latched from the new cur value: pulse_us = MIN_US + ((cur*SCALE)>>8), where SCALE = ((MAX_US-MIN_US)*256+90)/180, i.e. rounded. With defaults SCALE=2844, 0°→500, 90°→1499, 180°→2499.
  - A write accepted in cycle F updates tgt but is not used by the step in cycle F.
- **Output:** pwm_out[i] is registered as pwm_out[i] = (frame_us < pulse_us[i]). A new frame's pulse_us therefore takes effect only at frame boundaries, so no glitched or runt pulse is produced.
- busy = OR over all channels of (cur[i] != tgt[i]), registered.
- **Display:** a registered decode of cur[disp_sel]. Segment vector bit0=a .. bit6=g, active-low. Digit 3 shows disp_sel in hex.
  - If disp_sel >= NUM_CH, all four digits show "-", i.e. 7'b0111111.

## Timing
- **Reset values:** pwm_out=0, frame_tick=0, busy=0, wr_ready=0, counters=0, tgt=cur=RESET_ANGLE. The display shows channel 0 at RESET_ANGLE starting one cycle after reset is released.
- The first non-reset cycle is a frame-start cycle F.
- pwm_out rises at F+1 and stays high for exactly pulse_us*CYC_PER_US cycles. The frame period is PERIOD_US*CYC_PER_US cycles.
- frame_tick is high only in cycle F+1.
- Write-to-output latency: the pulse changes in the frame whose F comes first after the write is accepted.
  - If a write is accepted in cycle F, the change appears one frame later.
- Reset asserted mid-pulse drops pwm_out to 0 at the next edge. Writes presented during reset are lost.
- The display and busy lag cur by one cycle.

## Test plan
- Set params CLK_HZ=1_000_000, PERIOD_US=3000, SLEW_STEP=0. Release reset -> every pwm_out goes high at F+1 for 1499 cycles, with a period of 3000 cycles; frame_tick pulses every 3000 cycles.
- Write ch2=180, then ch0=0, mid-frame -> the next frame shows ch2 high for 2499 cycles and ch0 high for 500 cycles; the other channels stay at 1499; the current frame is unchanged.
- Set SLEW_STEP=2, write ch1=100 -> cur goes 92, 94 … 100 over 5 frames; busy falls the cycle after cur reaches 100; the display reads "1100".
- Write wr_angle=250 to ch3 -> clamped to 180 with pulse 2499. Write wr_ch=7 -> no channel changes and no hang. Write the same channel twice in one frame (40, then 60) -> only 60 is applied.
- Write in exactly cycle F -> the pulse changes one frame later. Assert reset during a pulse -> pwm_out=0 next cycle; after release all channels return to 1499.
- Set disp_sel=4 with ch4=7 -> the display decodes "4007". Set disp_sel=9 -> all four digits show 7'b0111111.
